// File: rtl/mem_arb.sv
// rtl/mem_arb.sv - two-port (instruction/data) arbiter and sequencer in front of mem_sys; `MEM_ARB_RR_EN selects round-robin ties
module mem_arb #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_50m,
    input  logic              rst_n,
    input  logic              i_valid,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_done,
    input  logic              d_valid,
    input  logic              d_wr,
    input  logic              d_rd,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              mem_valid,
    output logic              mem_wr,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_done,
    input  logic              sdram_init_done,
    output logic              busy,
    output logic              owner_d
);

    typedef enum logic [1:0] {
        WAIT_INIT = 2'd0,
        IDLE      = 2'd1,
        ISSUE     = 2'd2,
        RELEASE   = 2'd3
    } state_t;

    state_t state, state_nxt;
    logic   grant_i, grant_d, tie_d, d_noop;

    assign d_noop = !d_wr && !d_rd;
    assign busy   = (state == ISSUE) || (state == RELEASE);

    always_comb begin
`ifdef MEM_ARB_RR_EN
        tie_d = !owner_d;
`else
        tie_d = 1'b1;
`endif
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        state_nxt = state;
        case (state)
            WAIT_INIT: if (sdram_init_done) state_nxt = IDLE;
            IDLE: begin
                if (!sdram_init_done) begin
                    state_nxt = WAIT_INIT;
                end else if (i_valid || d_valid) begin
                    if (i_valid && d_valid) begin
                        grant_d = tie_d;
                        grant_i = !tie_d;
                    end else begin
                        grant_d = d_valid;
                        grant_i = i_valid;
                    end
                    // a data no-op never touches mem_sys, so skip straight to RELEASE
                    state_nxt = (grant_d && d_noop) ? RELEASE : ISSUE;
                end
            end
            ISSUE:   if (mem_done) state_nxt = RELEASE;
            RELEASE: if (!mem_done) state_nxt = IDLE;
            default: state_nxt = WAIT_INIT;
        endcase
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) state <= WAIT_INIT;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            mem_valid <= 1'b0;
            mem_wr    <= 1'b0;
            mem_rd    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            i_done    <= 1'b0;
            d_done    <= 1'b0;
            owner_d   <= 1'b1;
        end else begin
            i_done <= 1'b0;
            d_done <= 1'b0;
            if (grant_i) begin
                owner_d   <= 1'b0;
                mem_valid <= 1'b1;
                mem_wr    <= 1'b0;
                mem_rd    <= 1'b1;
                mem_addr  <= i_addr;
            end
            if (grant_d) begin
                owner_d <= 1'b1;
                if (d_noop) begin
                    d_done <= 1'b1;
                end else begin
                    mem_valid <= 1'b1;
                    mem_wr    <= d_wr;
                    mem_rd    <= !d_wr;
                    mem_addr  <= d_addr;
                    mem_wdata <= d_wdata;
                end
            end
            if (state == ISSUE && mem_done) begin
                mem_valid <= 1'b0;
                mem_wr    <= 1'b0;
                mem_rd    <= 1'b0;
                if (mem_rd && owner_d)  d_rdata <= mem_rdata;
                if (mem_rd && !owner_d) i_rdata <= mem_rdata;
                if (owner_d) d_done <= 1'b1;
                else         i_done <= 1'b1;
            end
        end
    end

endmodule
